// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Brief    : Common data bus arbiter; one-entry buffer per producer, served
//            round-robin, one registered broadcast per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int TAG_WIDTH  = 5,
    parameter int DATA_WIDTH = 32,
    parameter int SRC_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]    req_tag,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_value,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            flush,
    output logic                            cdb_valid,
    output logic [TAG_WIDTH-1:0]            cdb_tag,
    output logic [DATA_WIDTH-1:0]           cdb_value,
    output logic [SRC_WIDTH-1:0]            cdb_src,
    output logic                            busy
);

    logic [NUM_REQ-1:0]    buf_valid_q;
    logic [NUM_REQ-1:0]    buf_valid_d;
    logic [TAG_WIDTH-1:0]  buf_tag_q   [NUM_REQ];
    logic [DATA_WIDTH-1:0] buf_value_q [NUM_REQ];
    logic [SRC_WIDTH-1:0]  last_grant_q;

    logic                  cdb_valid_q;
    logic [TAG_WIDTH-1:0]  cdb_tag_q;
    logic [DATA_WIDTH-1:0] cdb_value_q;
    logic [SRC_WIDTH-1:0]  cdb_src_q;

    logic                  grant_any;
    logic [SRC_WIDTH-1:0]  grant_idx;
    logic [NUM_REQ-1:0]    grant_vec;
    logic [NUM_REQ-1:0]    xfer;

    // Scan the rotation from farthest to nearest so the nearest occupied
    // buffer after last_grant is the one left standing.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last_grant_q) + k) % NUM_REQ;
            if (buf_valid_q[idx]) begin
                grant_any = 1'b1;
                grant_idx = SRC_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        grant_vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_vec[i] = grant_any && (grant_idx == SRC_WIDTH'(i));
        end
    end

    assign req_ready   = {NUM_REQ{~flush}} & (~buf_valid_q | grant_vec);
    assign xfer        = req_valid & req_ready;
    // A refill on the granted index wins over its clear.
    assign buf_valid_d = (buf_valid_q & ~grant_vec) | xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q  <= '0;
            cdb_valid_q  <= 1'b0;
            cdb_tag_q    <= '0;
            cdb_value_q  <= '0;
            cdb_src_q    <= '0;
            last_grant_q <= SRC_WIDTH'(NUM_REQ - 1);
        end else if (flush) begin
            buf_valid_q  <= '0;
            cdb_valid_q  <= 1'b0;
        end else begin
            buf_valid_q  <= buf_valid_d;
            cdb_valid_q  <= grant_any;
            if (grant_any) begin
                cdb_tag_q    <= buf_tag_q[grant_idx];
                cdb_value_q  <= buf_value_q[grant_idx];
                cdb_src_q    <= grant_idx;
                last_grant_q <= grant_idx;
            end
        end
    end

    // Payload storage needs no reset; buf_valid_q qualifies it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (xfer[i]) begin
                buf_tag_q[i]   <= req_tag[i*TAG_WIDTH +: TAG_WIDTH];
                buf_value_q[i] <= req_value[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_value = cdb_value_q;
    assign cdb_src   = cdb_src_q;
    assign busy      = |buf_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_arbiter
// Brief    : Scoreboard bench for cdb_arbiter; reference model of per-unit
//            pending results and rotating priority, randomised traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

    localparam int N  = 2;
    localparam int TW = 5;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic [N-1:0]      req_valid;
    logic [N*TW-1:0]   req_tag;
    logic [N*DW-1:0]   req_value;
    logic [N-1:0]      req_ready;
    logic              cdb_valid;
    logic [TW-1:0]     cdb_tag;
    logic [DW-1:0]     cdb_value;
    logic [0:0]        cdb_src;
    logic              busy;

    cdb_arbiter #(
        .NUM_REQ   (N),
        .TAG_WIDTH (TW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_value (req_value),
        .req_ready (req_ready),
        .flush     (flush),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_value (cdb_value),
        .cdb_src   (cdb_src),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] tag;
        logic [DW-1:0] val;
        int            src;
    } bc_t;

    bc_t           exp_q[$];
    int            vectors    = 0;
    int            miscompares = 0;

    // Reference model: what each unit has parked, and who was served last.
    bit            pend  [N];
    logic [TW-1:0] ptag  [N];
    logic [DW-1:0] pval  [N];
    int            last;

    // Producer side: the item each unit is currently offering.
    bit            hold_v   [N];
    logic [TW-1:0] hold_tag [N];
    logic [DW-1:0] hold_val [N];
    int            seq = 0;
    bit            stop_mon = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic offer(input int u, input logic [TW-1:0] t, input logic [DW-1:0] v);
        hold_v[u]   = 1'b1;
        hold_tag[u] = t;
        hold_val[u] = v;
    endtask

    // One clock: drive inputs, check readiness/busy, advance the model.
    task automatic step(input bit r, input bit f, input bit [N-1:0] want);
        bit [N-1:0] rdy;
        bit         any;
        int         win;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (!hold_v[i] && want[i]) begin
                offer(i, TW'($urandom), (DW'(i) << 28) | DW'(seq));
                seq++;
            end
        end
        rst   = r;
        flush = f;
        for (int i = 0; i < N; i++) begin
            req_valid[i]            = hold_v[i];
            req_tag[i*TW +: TW]     = hold_v[i] ? hold_tag[i] : '0;
            req_value[i*DW +: DW]   = hold_v[i] ? hold_val[i] : '0;
        end
        #1;
        win = -1;
        for (int k = 1; k <= N; k++) begin
            if (win < 0 && pend[(last + k) % N]) win = (last + k) % N;
        end
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            rdy[i] = !f && (!pend[i] || win == i);
            any    = any | pend[i];
        end
        if (!r) begin
            check("req_ready", 64'(req_ready), 64'(rdy));
            check("busy", 64'(busy), 64'(any));
        end
        if (r || f) begin
            for (int i = 0; i < N; i++) begin
                pend[i]   = 1'b0;
                hold_v[i] = 1'b0;
            end
            if (r) last = N - 1;
        end else begin
            if (win >= 0) begin
                exp_q.push_back('{tag: ptag[win], val: pval[win], src: win});
                pend[win] = 1'b0;
                last      = win;
            end
            for (int i = 0; i < N; i++) begin
                if (hold_v[i] && rdy[i]) begin
                    pend[i]   = 1'b1;
                    ptag[i]   = hold_tag[i];
                    pval[i]   = hold_val[i];
                    hold_v[i] = 1'b0;
                end
            end
        end
    endtask

    // Monitor: every broadcast must match the oldest expected one, and an
    // expected broadcast must appear right after the edge that granted it.
    initial begin
        bc_t e;
        forever begin
            @(posedge clk);
            #2;
            if (!stop_mon) begin
                if (cdb_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check("cdb_spurious", 64'(cdb_valid), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("cdb_tag", 64'(cdb_tag), 64'(e.tag));
                        check("cdb_value", 64'(cdb_value), 64'(e.val));
                        check("cdb_src", 64'(cdb_src), 64'(e.src));
                    end
                end else if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("cdb_missing", 64'(cdb_valid), 64'd1);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        req_valid = '0;
        req_tag = '0;
        req_value = '0;
        last = N - 1;
        for (int i = 0; i < N; i++) begin
            pend[i]   = 1'b0;
            hold_v[i] = 1'b0;
        end

        // Reset held two cycles with both units requesting.
        step(1'b1, 1'b0, 2'b11);
        step(1'b1, 1'b0, 2'b11);
        step(1'b0, 1'b0, 2'b00);
        check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
        check("rst_cdb_tag", 64'(cdb_tag), 64'd0);
        check("rst_cdb_value", 64'(cdb_value), 64'd0);
        check("rst_cdb_src", 64'(cdb_src), 64'd0);

        // Single ALU result.
        offer(0, 5'd1, 32'h0000_00AA);
        step(1'b0, 1'b0, 2'b00);
        repeat (3) step(1'b0, 1'b0, 2'b00);

        // Contention right after reset; MEM offers again while blocked.
        step(1'b1, 1'b0, 2'b00);
        offer(0, 5'd0, 32'h11);
        offer(1, 5'd1, 32'h22);
        step(1'b0, 1'b0, 2'b00);
        offer(1, 5'd2, 32'h33);
        step(1'b0, 1'b0, 2'b00);
        repeat (4) step(1'b0, 1'b0, 2'b00);

        // Round-robin streaming from both units.
        repeat (16) step(1'b0, 1'b0, 2'b11);
        repeat (4) step(1'b0, 1'b0, 2'b00);

        // ALU alone, back-to-back through the refill path.
        repeat (8) step(1'b0, 1'b0, 2'b01);
        repeat (3) step(1'b0, 1'b0, 2'b00);

        // Flush with both buffers full and a broadcast on the bus.
        step(1'b0, 1'b0, 2'b11);
        step(1'b0, 1'b0, 2'b11);
        step(1'b0, 1'b1, 2'b11);
        step(1'b0, 1'b0, 2'b00);
        check("flush_cdb_valid", 64'(cdb_valid), 64'd0);
        check("flush_busy", 64'(busy), 64'd0);
        step(1'b0, 1'b0, 2'b11);
        repeat (4) step(1'b0, 1'b0, 2'b00);

        // Randomised traffic with occasional flush and reset.
        for (int c = 0; c < 800; c++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0,
                 2'(($urandom_range(0, 3) != 0 ? 1 : 0) | ($urandom_range(0, 2) != 0 ? 2 : 0)));
        end
        repeat (4) step(1'b0, 1'b0, 2'b00);

        @(posedge clk);
        #3;
        stop_mon = 1'b1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
